// File: rtl/serial_tl_pkg.sv
// Shared definitions for the host-side serial TileLink bridge.
// Holds the default word width and the TX state encoding.
package serial_tl_pkg;

    localparam int SERIAL_TL_WORD_W = 32;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;

endpackage

// File: rtl/serial_tl_deser.sv
// RX deserializer: collects LSB-first bits into words and parks each finished
// word in a one-entry holding register in front of the host.
module serial_tl_deser
    import serial_tl_pkg::*;
#(
    parameter int WORD_W = SERIAL_TL_WORD_W,
    parameter int CNT_W  = $clog2(WORD_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              stall
);

    logic [WORD_W-1:1] rx_sr;
    logic [CNT_W-1:0]  rx_cnt;
    logic              hold_valid;
    logic [WORD_W-1:0] hold_data;
    logic [WORD_W-1:0] word;
    logic              cnt_last;
    logic              fire;

    // Only the final bit of a word can be refused, and only while the previous word is still unread.
    assign cnt_last  = (rx_cnt == CNT_W'(WORD_W - 1));
    assign in_ready  = !(cnt_last && hold_valid && !out_ready);
    assign stall     = !in_ready;
    assign fire      = in_valid && in_ready;
    assign word      = {in_bit, rx_sr};
    assign out_valid = hold_valid;
    assign out_data  = hold_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_sr      <= '0;
            rx_cnt     <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else begin
            if (fire) begin
                rx_sr  <= word[WORD_W-1:1];
                rx_cnt <= cnt_last ? '0 : rx_cnt + 1'b1;
            end
            // A completing word wins over a pop, so valid stays high when both happen together.
            if (fire && cnt_last) begin
                hold_valid <= 1'b1;
                hold_data  <= word;
            end else if (out_ready) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_tl_host_bridge.sv
// Host-side endpoint of the 1-bit serial TileLink link: serializes host words
// toward the chip (LSB-first) and deserializes the chip's bit stream back.
module serial_tl_host_bridge
    import serial_tl_pkg::*;
#(
    parameter int WORD_W = SERIAL_TL_WORD_W,
    parameter int CNT_W  = $clog2(WORD_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_tx_valid,
    output logic              host_tx_ready,
    input  logic [WORD_W-1:0] host_tx_data,
    output logic              host_rx_valid,
    input  logic              host_rx_ready,
    output logic [WORD_W-1:0] host_rx_data,
    output logic              serial_tl_bits_in_valid,
    output logic              serial_tl_bits_in_bits,
    input  logic              serial_tl_bits_in_ready,
    input  logic              serial_tl_bits_out_valid,
    input  logic              serial_tl_bits_out_bits,
    output logic              serial_tl_bits_out_ready,
    output logic              tx_busy,
    output logic              rx_overrun_stall
);

    tx_state_e         state, state_d;
    logic [WORD_W-1:0] tx_sr, tx_sr_d;
    logic [CNT_W-1:0]  tx_cnt, tx_cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= TX_IDLE;
            tx_sr  <= '0;
            tx_cnt <= '0;
        end else begin
            state  <= state_d;
            tx_sr  <= tx_sr_d;
            tx_cnt <= tx_cnt_d;
        end
    end

    // On the last accepted bit the host may hand over the next word in the same cycle, giving no gap.
    always_comb begin
        state_d                 = state;
        tx_sr_d                 = tx_sr;
        tx_cnt_d                = tx_cnt;
        host_tx_ready           = 1'b0;
        serial_tl_bits_in_valid = 1'b0;
        serial_tl_bits_in_bits  = 1'b0;
        case (state)
            TX_IDLE: begin
                host_tx_ready = 1'b1;
                if (host_tx_valid) begin
                    tx_sr_d  = host_tx_data;
                    tx_cnt_d = '0;
                    state_d  = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                serial_tl_bits_in_valid = 1'b1;
                serial_tl_bits_in_bits  = tx_sr[0];
                if (serial_tl_bits_in_ready) begin
                    if (tx_cnt == CNT_W'(WORD_W - 1)) begin
                        host_tx_ready = 1'b1;
                        tx_cnt_d      = '0;
                        if (host_tx_valid) begin
                            tx_sr_d = host_tx_data;
                        end else begin
                            tx_sr_d = tx_sr >> 1;
                            state_d = TX_IDLE;
                        end
                    end else begin
                        tx_sr_d  = tx_sr >> 1;
                        tx_cnt_d = tx_cnt + 1'b1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign tx_busy = (state == TX_SHIFT);

    serial_tl_deser #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_deser (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (serial_tl_bits_out_valid),
        .in_bit    (serial_tl_bits_out_bits),
        .in_ready  (serial_tl_bits_out_ready),
        .out_valid (host_rx_valid),
        .out_ready (host_rx_ready),
        .out_data  (host_rx_data),
        .stall     (rx_overrun_stall)
    );

endmodule

// File: tb/tb_serial_tl_host_bridge.sv
// Directed bench for serial_tl_host_bridge: TX serialization, RX assembly,
// backpressure in both directions and reset in the middle of a word.
module tb_serial_tl_host_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        host_tx_valid = 1'b0;
    logic        host_tx_ready;
    logic [31:0] host_tx_data = '0;
    logic        host_rx_valid;
    logic        host_rx_ready = 1'b0;
    logic [31:0] host_rx_data;
    logic        serial_tl_bits_in_valid;
    logic        serial_tl_bits_in_bits;
    logic        serial_tl_bits_in_ready = 1'b1;
    logic        serial_tl_bits_out_valid = 1'b0;
    logic        serial_tl_bits_out_bits = 1'b0;
    logic        serial_tl_bits_out_ready;
    logic        tx_busy;
    logic        rx_overrun_stall;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    serial_tl_host_bridge dut (
        .clock                    (clock),
        .reset                    (reset),
        .host_tx_valid            (host_tx_valid),
        .host_tx_ready            (host_tx_ready),
        .host_tx_data             (host_tx_data),
        .host_rx_valid            (host_rx_valid),
        .host_rx_ready            (host_rx_ready),
        .host_rx_data             (host_rx_data),
        .serial_tl_bits_in_valid  (serial_tl_bits_in_valid),
        .serial_tl_bits_in_bits   (serial_tl_bits_in_bits),
        .serial_tl_bits_in_ready  (serial_tl_bits_in_ready),
        .serial_tl_bits_out_valid (serial_tl_bits_out_valid),
        .serial_tl_bits_out_bits  (serial_tl_bits_out_bits),
        .serial_tl_bits_out_ready (serial_tl_bits_out_ready),
        .tx_busy                  (tx_busy),
        .rx_overrun_stall         (rx_overrun_stall)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic tx_valid, input logic [31:0] tx_data);
        host_tx_valid = tx_valid;
        host_tx_data  = tx_data;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_host_tx_ready"}, 32'(host_tx_ready), 32'd1);
        checkOutput({tag, "_host_rx_valid"}, 32'(host_rx_valid), 32'd0);
        checkOutput({tag, "_host_rx_data"}, host_rx_data, 32'd0);
        checkOutput({tag, "_bits_in_valid"}, 32'(serial_tl_bits_in_valid), 32'd0);
        checkOutput({tag, "_bits_in_bits"}, 32'(serial_tl_bits_in_bits), 32'd0);
        checkOutput({tag, "_bits_out_ready"}, 32'(serial_tl_bits_out_ready), 32'd1);
        checkOutput({tag, "_tx_busy"}, 32'(tx_busy), 32'd0);
        checkOutput({tag, "_rx_overrun_stall"}, 32'(rx_overrun_stall), 32'd0);
    endtask

    // Full-rate TX of one word: host_tx_ready must stay low until the last bit is on the wire.
    task automatic sendTxWord(input logic [31:0] w, input string tag);
        @(negedge clock);
        applyStimulus(1'b1, w);
        #1;
        checkOutput({tag, "_accept_ready"}, 32'(host_tx_ready), 32'd1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            if (i == 0) applyStimulus(1'b0, 32'd0);
            #1;
            checkOutput($sformatf("%s_valid%0d", tag, i), 32'(serial_tl_bits_in_valid), 32'd1);
            checkOutput($sformatf("%s_bit%0d", tag, i), 32'(serial_tl_bits_in_bits), 32'(w[i]));
            checkOutput($sformatf("%s_txready%0d", tag, i), 32'(host_tx_ready), (i == 31) ? 32'd1 : 32'd0);
        end
        @(negedge clock);
        #1;
        checkOutput({tag, "_idle_valid"}, 32'(serial_tl_bits_in_valid), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
    endtask

    task automatic streamRxWord(input logic [31:0] w, input string tag);
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            serial_tl_bits_out_valid = 1'b1;
            serial_tl_bits_out_bits  = w[i];
            #1;
            checkOutput($sformatf("%s_outready%0d", tag, i), 32'(serial_tl_bits_out_ready), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] rcv;
        logic        prev_ready;
        logic        prev_bit;
        int          idx;
        int          cyc;

        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        checkResetValues("reset");
        reset = 1'b0;

        sendTxWord(32'hA5A5_0001, "tx_single");

        // Back-to-back words with host_tx_valid held across the boundary.
        @(negedge clock);
        applyStimulus(1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (i == 0) host_tx_data = 32'h0000_0000;
            if (i == 32) applyStimulus(1'b0, 32'd0);
            #1;
            checkOutput($sformatf("b2b_valid%0d", i), 32'(serial_tl_bits_in_valid), 32'd1);
            checkOutput($sformatf("b2b_bit%0d", i), 32'(serial_tl_bits_in_bits), (i < 32) ? 32'd1 : 32'd0);
        end
        @(negedge clock);
        #1;
        checkOutput("b2b_idle_valid", 32'(serial_tl_bits_in_valid), 32'd0);

        // TX with bits_in_ready toggling each cycle, starting low.
        @(negedge clock);
        applyStimulus(1'b1, 32'h1234_5678);
        rcv        = '0;
        idx        = 0;
        cyc        = 0;
        prev_ready = 1'b1;
        prev_bit   = 1'b0;
        while (idx < 32 && cyc < 200) begin
            @(negedge clock);
            if (cyc == 0) applyStimulus(1'b0, 32'd0);
            serial_tl_bits_in_ready = cyc[0];
            #1;
            checkOutput($sformatf("bp_valid%0d", cyc), 32'(serial_tl_bits_in_valid), 32'd1);
            if (!prev_ready)
                checkOutput($sformatf("bp_stable%0d", cyc), 32'(serial_tl_bits_in_bits), 32'(prev_bit));
            if (serial_tl_bits_in_ready) begin
                rcv[idx] = serial_tl_bits_in_bits;
                idx++;
            end
            prev_ready = serial_tl_bits_in_ready;
            prev_bit   = serial_tl_bits_in_bits;
            cyc++;
        end
        checkOutput("bp_word", rcv, 32'h1234_5678);
        checkOutput("bp_cycles", 32'(cyc), 32'd64);
        @(negedge clock);
        serial_tl_bits_in_ready = 1'b1;

        // Single RX word, host not yet consuming.
        streamRxWord(32'hDEAD_BEEF, "rx_single");
        checkOutput("rx_single_prevalid", 32'(host_rx_valid), 32'd0);
        @(negedge clock);
        serial_tl_bits_out_valid = 1'b0;
        #1;
        checkOutput("rx_single_valid", 32'(host_rx_valid), 32'd1);
        checkOutput("rx_single_data", host_rx_data, 32'hDEAD_BEEF);
        host_rx_ready = 1'b1;
        @(negedge clock);
        host_rx_ready = 1'b0;
        #1;
        checkOutput("rx_single_popped", 32'(host_rx_valid), 32'd0);

        // RX stall: second word's last bit must wait for the first word to be popped.
        streamRxWord(32'h0000_0001, "rx_w1");
        for (int i = 0; i < 31; i++) begin
            @(negedge clock);
            serial_tl_bits_out_valid = 1'b1;
            serial_tl_bits_out_bits  = (i == 1);
            #1;
            checkOutput($sformatf("rx_w2_outready%0d", i), 32'(serial_tl_bits_out_ready), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            serial_tl_bits_out_valid = 1'b1;
            serial_tl_bits_out_bits  = 1'b0;
            #1;
            checkOutput($sformatf("rx_stall_ready%0d", i), 32'(serial_tl_bits_out_ready), 32'd0);
            checkOutput($sformatf("rx_stall_flag%0d", i), 32'(rx_overrun_stall), 32'd1);
            checkOutput($sformatf("rx_stall_data%0d", i), host_rx_data, 32'h0000_0001);
        end
        @(negedge clock);
        host_rx_ready = 1'b1;
        #1;
        checkOutput("rx_pop_outready", 32'(serial_tl_bits_out_ready), 32'd1);
        checkOutput("rx_pop_stall", 32'(rx_overrun_stall), 32'd0);
        @(negedge clock);
        host_rx_ready            = 1'b0;
        serial_tl_bits_out_valid = 1'b0;
        #1;
        checkOutput("rx_w2_valid", 32'(host_rx_valid), 32'd1);
        checkOutput("rx_w2_data", host_rx_data, 32'h0000_0002);
        host_rx_ready = 1'b1;
        @(negedge clock);
        host_rx_ready = 1'b0;

        // Reset after 10 TX bits while an RX word is also partially received.
        @(negedge clock);
        applyStimulus(1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i == 0) applyStimulus(1'b0, 32'd0);
            serial_tl_bits_out_valid = 1'b1;
            serial_tl_bits_out_bits  = 1'b1;
            #1;
            checkOutput($sformatf("rst_tx_bit%0d", i), 32'(serial_tl_bits_in_bits), 32'd1);
        end
        @(negedge clock);
        reset                    = 1'b1;
        serial_tl_bits_out_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkResetValues("midreset");

        sendTxWord(32'h0000_0003, "tx_after_reset");

        streamRxWord(32'h0F0F_1234, "rx_after_reset");
        @(negedge clock);
        serial_tl_bits_out_valid = 1'b0;
        #1;
        checkOutput("rx_after_reset_valid", 32'(host_rx_valid), 32'd1);
        checkOutput("rx_after_reset_data", host_rx_data, 32'h0F0F_1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
